t03_layer_compositor: RTL and testbench

//  Parametrised, pipelined pixel compositor between the sprite/text generators and the VGA DAC.

---
 rtl/t03_compositor_pkg.sv | 39 +++
 rtl/t03_blink_timer.sv | 38 +++
 rtl/t03_layer_compositor.sv | 158 +++++++++++++++
 tb/tb_t03_layer_compositor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/t03_compositor_pkg.sv
// Shared types and helpers for the layer compositor.
// Region decode, default palette and screen bounds.
package t03_compositor_pkg;

    localparam int BND_W = 16;

    typedef enum logic [1:0] {
        REG_OUT  = 2'd0,
        REG_PLAY = 2'd1,
        REG_HUD  = 2'd2
    } region_e;

    localparam logic [7:0] PAL_OUT_RST  = 8'h00;
    localparam logic [7:0] PAL_PLAY_RST = 8'h57;
    localparam logic [7:0] PAL_HUD_RST  = 8'h14;

    typedef struct packed {
        logic [BND_W-1:0] x_min;
        logic [BND_W-1:0] x_max;
        logic [BND_W-1:0] y_min;
        logic [BND_W-1:0] y_split;
        logic [BND_W-1:0] y_max;
    } bounds_t;

    function automatic region_e region_of(
        input logic [BND_W-1:0] h,
        input logic [BND_W-1:0] v,
        input bounds_t          b
    );
        logic in_x;
        in_x = (h > b.x_min) && (h < b.x_max);
        if (in_x && (v > b.y_min) && (v < b.y_split))
            return REG_PLAY;
        if (in_x && (v >= b.y_split) && (v < b.y_max))
            return REG_HUD;
        return REG_OUT;
    endfunction

endpackage

// File: rtl/t03_blink_timer.sv
// Frame counter driving the shared blink phase.
// Phase flips every BLINK_FRAMES frame starts.
module t03_blink_timer #(
    parameter int CNT_W        = 11,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             pix_valid,
    input  logic [CNT_W-1:0] Hcnt,
    input  logic [CNT_W-1:0] Vcnt,
    output logic             blink_phase
);

    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt;
    logic            frame_start;

    assign frame_start = pix_valid && (Hcnt == '0) && (Vcnt == '0);

    // Count frame starts, wrap and flip phase at the half-period end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt == LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

endmodule

// File: rtl/t03_layer_compositor.sv
// Two-stage pixel compositor: sprites, text, palette background.
// Stage 1 decodes region and blink, stage 2 picks the winner.
module t03_layer_compositor
    import t03_compositor_pkg::*;
#(
    parameter int COLOR_W      = 8,
    parameter int CNT_W        = 11,
    parameter int NUM_LAYERS   = 2,
    parameter int X_MIN        = 37,
    parameter int X_MAX        = 600,
    parameter int Y_MIN        = 29,
    parameter int Y_SPLIT      = 600,
    parameter int Y_MAX        = 800,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          pix_valid,
    input  logic [CNT_W-1:0]              Hcnt,
    input  logic [CNT_W-1:0]              Vcnt,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [COLOR_W-1:0]            text_sprite,
    input  logic [COLOR_W-1:0]            text_color,
    input  logic [NUM_LAYERS:0]           blink_mask,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_addr,
    input  logic [COLOR_W-1:0]            cfg_wdata,
    output logic [COLOR_W-1:0]            color_out,
    output logic                          color_valid,
    output logic                          blink_phase
);

    // Bounds are truncated to the counter width so all compares stay CNT_W unsigned
    localparam logic [CNT_W-1:0] XMIN_C  = CNT_W'(X_MIN);
    localparam logic [CNT_W-1:0] XMAX_C  = CNT_W'(X_MAX);
    localparam logic [CNT_W-1:0] YMIN_C  = CNT_W'(Y_MIN);
    localparam logic [CNT_W-1:0] YSPL_C  = CNT_W'(Y_SPLIT);
    localparam logic [CNT_W-1:0] YMAX_C  = CNT_W'(Y_MAX);

    localparam bounds_t BND = '{
        x_min:   BND_W'(XMIN_C),
        x_max:   BND_W'(XMAX_C),
        y_min:   BND_W'(YMIN_C),
        y_split: BND_W'(YSPL_C),
        y_max:   BND_W'(YMAX_C)
    };

    logic [COLOR_W-1:0] pal_out;
    logic [COLOR_W-1:0] pal_play;
    logic [COLOR_W-1:0] pal_hud;

    logic [NUM_LAYERS-1:0][COLOR_W-1:0] eff;
    logic                               text_vis;
    region_e                            region_d;

    logic                               v1;
    region_e                            s1_region;
    logic [NUM_LAYERS-1:0][COLOR_W-1:0] s1_layer;
    logic                               s1_text_on;
    logic [COLOR_W-1:0]                 s1_text_color;

    logic [COLOR_W-1:0] bg;
    logic [COLOR_W-1:0] pix_next;

    t03_blink_timer #(
        .CNT_W        (CNT_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk         (clk),
        .nrst        (nrst),
        .pix_valid   (pix_valid),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .blink_phase (blink_phase)
    );

    assign region_d = region_of(BND_W'(Hcnt), BND_W'(Vcnt), BND);

    // Blank blinking layers and text while the phase is off
    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            eff[i] = layer_color[i*COLOR_W +: COLOR_W]
                   & ~{COLOR_W{blink_mask[i] & ~blink_phase}};
        end
        text_vis = (text_sprite != '0)
                 && !(blink_mask[NUM_LAYERS] && !blink_phase);
    end

    // Palette registers; reserved address writes are dropped
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pal_out  <= COLOR_W'(PAL_OUT_RST);
            pal_play <= COLOR_W'(PAL_PLAY_RST);
            pal_hud  <= COLOR_W'(PAL_HUD_RST);
        end else if (cfg_we) begin
            case (cfg_addr)
                2'd0:    pal_out  <= cfg_wdata;
                2'd1:    pal_play <= cfg_wdata;
                2'd2:    pal_hud  <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Stage 1: capture decoded pixel; valid shifts every cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1            <= 1'b0;
            s1_region     <= REG_OUT;
            s1_layer      <= '0;
            s1_text_on    <= 1'b0;
            s1_text_color <= '0;
        end else begin
            v1 <= pix_valid;
            if (pix_valid) begin
                s1_region     <= region_d;
                s1_layer      <= eff;
                s1_text_on    <= text_vis;
                s1_text_color <= text_color;
            end
        end
    end

    // Background lookup reads the palette as it stands this cycle
    always_comb begin
        bg = pal_out;
        case (s1_region)
            REG_PLAY: bg = pal_play;
            REG_HUD:  bg = pal_hud;
            default:  bg = pal_out;
        endcase
    end

    // Priority: lowest-index opaque layer, then text, then background
    always_comb begin
        pix_next = bg;
        if (s1_text_on)
            pix_next = s1_text_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (s1_layer[i] != '0)
                pix_next = s1_layer[i];
        end
    end

    // Stage 2: output register holds its value across invalid cycles
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            color_valid <= v1;
            if (v1)
                color_out <= pix_next;
        end
    end

endmodule

// File: tb/tb_t03_layer_compositor.sv
// Directed bench for the layer compositor.
// Hand-computed pixels, region edges, palette, blink, reset.
module tb_t03_layer_compositor;

    logic        clk = 1'b0;
    logic        nrst;
    logic        pix_valid;
    logic [10:0] Hcnt;
    logic [10:0] Vcnt;
    logic [15:0] layer_color;
    logic [7:0]  text_sprite;
    logic [7:0]  text_color;
    logic [2:0]  blink_mask;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  color_out;
    logic        color_valid;
    logic        blink_phase;

    int checks   = 0;
    int failures = 0;

    t03_layer_compositor #(
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .pix_valid   (pix_valid),
        .Hcnt        (Hcnt),
        .Vcnt        (Vcnt),
        .layer_color (layer_color),
        .text_sprite (text_sprite),
        .text_color  (text_color),
        .blink_mask  (blink_mask),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .color_out   (color_out),
        .color_valid (color_valid),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag,
                        input logic [10:0] h, input logic [10:0] v,
                        input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] ts, input logic [7:0] tc,
                        input logic [7:0] exp);
        Hcnt        = h;
        Vcnt        = v;
        layer_color = {l1, l0};
        text_sprite = ts;
        text_color  = tc;
        pix_valid   = 1'b1;
        tick();
        pix_valid = 1'b0;
        chk({tag, "/lat1"}, 32'(color_valid), 32'd0);
        tick();
        chk({tag, "/px"}, 32'(color_out), 32'(exp));
        chk({tag, "/vld"}, 32'(color_valid), 32'd1);
    endtask

    initial begin
        nrst        = 1'b0;
        pix_valid   = 1'b0;
        Hcnt        = '0;
        Vcnt        = '0;
        layer_color = '0;
        text_sprite = '0;
        text_color  = '0;
        blink_mask  = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
        tick();
        tick();
        chk("rst_out", 32'(color_out), 32'h00);
        chk("rst_vld", 32'(color_valid), 32'd0);
        chk("rst_phase", 32'(blink_phase), 32'd1);
        nrst = 1'b1;
        tick();

        send("play_bg", 100, 100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57);

        send("l0_wins", 100, 700, 8'hE0, 8'h1C, 8'h00, 8'h00, 8'hE0);
        send("l1_only", 100, 700, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h1C);
        send("text", 100, 700, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF);
        send("l1_over_txt", 100, 700, 8'h00, 8'h1C, 8'h01, 8'hFF, 8'h1C);
        send("black_txt", 100, 700, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        send("hud_bg", 100, 700, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h14);

        send("edge_x37", 37, 100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send("edge_x600", 600, 100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send("edge_y29", 100, 29, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send("edge_y800", 100, 800, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send("edge_38_30", 38, 30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57);
        send("edge_599_600", 599, 600, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14);
        send("edge_y599", 100, 599, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57);

        Hcnt        = 100;
        Vcnt        = 100;
        layer_color = '0;
        text_sprite = '0;
        pix_valid   = 1'b1;
        tick();
        cfg_we    = 1'b1;
        cfg_addr  = 2'd1;
        cfg_wdata = 8'h03;
        tick();
        cfg_we    = 1'b0;
        pix_valid = 1'b0;
        chk("pal_old", 32'(color_out), 32'h57);
        tick();
        chk("pal_new", 32'(color_out), 32'h03);
        chk("pal_new_vld", 32'(color_valid), 32'd1);
        tick();

        cfg_we    = 1'b1;
        cfg_addr  = 2'd3;
        cfg_wdata = 8'hAA;
        tick();
        cfg_we = 1'b0;
        send("rsv_out", 10, 10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send("rsv_play", 100, 100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
        send("rsv_hud", 100, 700, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14);

        blink_mask = 3'b001;
        send("bl_on", 100, 100, 8'hE0, 8'h00, 8'h00, 8'h00, 8'hE0);
        send("frame1", 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("ph_f1", 32'(blink_phase), 32'd1);
        send("frame2", 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("ph_f2", 32'(blink_phase), 32'd0);
        send("bl_l1", 100, 100, 8'hE0, 8'h1C, 8'h00, 8'h00, 8'h1C);
        send("bl_bg", 100, 100, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h03);
        send("bl_txt", 100, 100, 8'hE0, 8'h00, 8'h01, 8'hFF, 8'hFF);
        blink_mask = 3'b100;
        send("txt_blink", 100, 100, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h03);
        blink_mask = 3'b001;
        send("frame3", 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("ph_f3", 32'(blink_phase), 32'd0);
        send("frame4", 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("ph_f4", 32'(blink_phase), 32'd1);
        send("bl_back", 100, 100, 8'hE0, 8'h00, 8'h00, 8'h00, 8'hE0);
        send("frame5", 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send("frame6", 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        chk("ph_f6", 32'(blink_phase), 32'd0);

        Hcnt        = 100;
        Vcnt        = 100;
        layer_color = '0;
        text_sprite = '0;
        pix_valid   = 1'b1;
        tick();
        tick();
        chk("pre_rst_px", 32'(color_out), 32'h03);
        nrst = 1'b0;
        #1;
        chk("mid_rst_px", 32'(color_out), 32'h00);
        chk("mid_rst_vld", 32'(color_valid), 32'd0);
        chk("mid_rst_ph", 32'(blink_phase), 32'd1);
        tick();
        pix_valid = 1'b0;
        nrst      = 1'b1;
        tick();
        chk("post_rst_vld", 32'(color_valid), 32'd0);
        send("post_play", 100, 100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h57);
        send("post_hud", 100, 700, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14);
        send("post_blink", 100, 100, 8'hE0, 8'h00, 8'h00, 8'h00, 8'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
